// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers.
// Provides Gray/binary conversion and the depth calculation.
package fifo_pkg;

  // Widest pointer the conversion helpers handle. Narrower pointers are
  // zero-extended on the way in and truncated on the way out.
  localparam int PTR_MAX_W = 16;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a zero-extended Gray code stay zero, so this also works for
  // any narrower width.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// STAGES-deep, WIDTH-bit flop synchroniser with asynchronous active-low reset.
// Used for Gray pointers crossing between the FIFO clock domains.
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // NOTE: the chain is a register array, not a RAM, so it is reset like any
  // flop; this keeps the synchronised pointer defined from the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_full_sync.sv
// Write-side pointer and full/almost-full/level controller for a dual-clock FIFO.
// Define WPTR_FULL_OVF_EN to add the sticky overflow flag (wovf / wovf_clr).
module wptr_full_sync
  import fifo_pkg::*;
#(
  parameter int ASIZE        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr_gray,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
`ifdef WPTR_FULL_OVF_EN
  input  logic             wovf_clr,
  output logic             wovf,
`endif
  output logic             wen
);

  localparam int PTR_W = ASIZE + 1;
  localparam int DEPTH = fifo_depth(ASIZE);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t AFULL_LEVEL = ptr_t'(DEPTH - AFULL_MARGIN);

  ptr_t wbin;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t rq;
  ptr_t rq_bin;
  ptr_t full_ptr;
  ptr_t level_next;

  sync_nff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_gray),
    .q     (rq)
  );

  // NOTE: every variable here is assigned on every pass, so no latch can be
  // inferred.
  always_comb begin
    wen        = winc & ~wfull;
    wbin_next  = wbin + ptr_t'(wen);
    wgray_next = ptr_t'(bin2gray(PTR_MAX_W'(wbin_next)));
    rq_bin     = ptr_t'(gray2bin(PTR_MAX_W'(rq)));
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full_ptr   = {~rq[ASIZE:ASIZE-1], rq[ASIZE-2:0]};
    level_next = wbin_next - rq_bin;
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // so the flags and pointers update together.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_ptr);
      wlevel       <= level_next;
      walmost_full <= (level_next >= AFULL_LEVEL);
    end
  end

  assign waddr = wbin[ASIZE-1:0];

`ifdef WPTR_FULL_OVF_EN
  // Set wins over clear so an overflow coinciding with a clear is not lost.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`endif

endmodule
